// File: rtl/n64_controller_responder.sv
// Purpose: N64 controller emulator on the open-drain joybus; decodes console command bytes and replies with identity or button frames.
// Latency: cmd_valid 3 PCLK after the raw stop-bit rising edge; reply starts 2*US_CYCLES after cmd_valid.
// Backpressure: none; the line protocol is strictly timed, and malformed frames are dropped with an rx_error pulse.
module n64_controller_responder #(
  parameter int US_CYCLES = 100
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        line_in,
  output logic        line_oe,
  input  logic [31:0] buttons,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy,
  output logic        rx_error
);

  localparam int CW = $clog2(5 * US_CYCLES);
  localparam logic [CW-1:0] US1 = CW'(US_CYCLES);
  localparam logic [CW-1:0] US2 = CW'(2 * US_CYCLES);
  localparam logic [CW-1:0] US3 = CW'(3 * US_CYCLES);
  localparam logic [CW-1:0] US4 = CW'(4 * US_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    RX_LOW,
    RX_HIGH,
    GAP,
    TX_BIT,
    TX_STOP
  } state_t;

  state_t state, state_nx;

  logic          sync1, sync2, line_q;
  logic          fall, rise;
  logic [CW-1:0] cnt, cnt_nx;
  logic [5:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    rx_sr, rx_sr_nx;
  logic [31:0]   tx_sr, tx_sr_nx;
  logic          line_oe_nx, cmd_valid_nx, rx_error_nx;
  logic [7:0]    cmd_byte_nx;

  // Two-flop synchronizer plus a delayed copy for edge detection; idle level is high.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= line_in;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign fall = line_q & ~sync2;
  assign rise = ~line_q & sync2;
  assign busy = (state != IDLE);

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      line_oe   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      rx_error  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      rx_sr     <= rx_sr_nx;
      tx_sr     <= tx_sr_nx;
      line_oe   <= line_oe_nx;
      cmd_valid <= cmd_valid_nx;
      cmd_byte  <= cmd_byte_nx;
      rx_error  <= rx_error_nx;
    end
  end

  // Next-state and datapath; cnt holds the number of cycles already spent in the current phase.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bit_cnt_nx   = bit_cnt;
    rx_sr_nx     = rx_sr;
    tx_sr_nx     = tx_sr;
    line_oe_nx   = 1'b0;
    cmd_valid_nx = 1'b0;
    cmd_byte_nx  = cmd_byte;
    rx_error_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          state_nx   = RX_LOW;
          cnt_nx     = CW'(1);
          bit_cnt_nx = '0;
          rx_sr_nx   = '0;
        end
      end

      RX_LOW: begin
        if (rise) begin
          if (cnt >= US4) begin
            // A low exactly 4 us long is malformed, stop bit included.
            rx_error_nx = 1'b1;
            state_nx    = IDLE;
          end else if (bit_cnt == 6'd8) begin
            cmd_byte_nx  = rx_sr;
            cmd_valid_nx = 1'b1;
            cnt_nx       = CW'(1);
            case (rx_sr)
              8'h00, 8'hff: begin
                tx_sr_nx   = {24'h050002, 8'h00};
                bit_cnt_nx = 6'd24;
                state_nx   = GAP;
              end
              8'h01: begin
                // Buttons are captured here so later changes cannot disturb the reply.
                tx_sr_nx   = buttons;
                bit_cnt_nx = 6'd32;
                state_nx   = GAP;
              end
              default: state_nx = IDLE;
            endcase
          end else begin
            rx_sr_nx   = {rx_sr[6:0], (cnt < US2)};
            bit_cnt_nx = bit_cnt + 6'd1;
            cnt_nx     = CW'(1);
            state_nx   = RX_HIGH;
          end
        end else if (cnt >= US4) begin
          rx_error_nx = 1'b1;
          state_nx    = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      RX_HIGH: begin
        // A falling edge wins over a coincident timeout.
        if (fall) begin
          state_nx = RX_LOW;
          cnt_nx   = CW'(1);
        end else if (cnt >= US4) begin
          rx_error_nx = 1'b1;
          state_nx    = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      GAP: begin
        if (cnt >= US2) begin
          state_nx   = TX_BIT;
          cnt_nx     = CW'(1);
          line_oe_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      TX_BIT: begin
        if (cnt >= US4) begin
          cnt_nx     = CW'(1);
          line_oe_nx = 1'b1;
          if (bit_cnt == 6'd1) begin
            state_nx = TX_STOP;
          end else begin
            bit_cnt_nx = bit_cnt - 6'd1;
            tx_sr_nx   = {tx_sr[30:0], 1'b0};
          end
        end else begin
          cnt_nx     = cnt + CW'(1);
          line_oe_nx = (cnt < (tx_sr[31] ? US1 : US3));
        end
      end

      TX_STOP: begin
        if (cnt >= US2) begin
          state_nx = IDLE;
        end else begin
          cnt_nx     = cnt + CW'(1);
          line_oe_nx = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Bench for n64_controller_responder: a console model drives random joybus frames,
// and a reference model builds the expected reply waveform from the command and button word.
// Line is modelled as open drain: low when either the console or the DUT pulls.
module tb_n64_controller_responder;

  localparam int US   = 4;
  localparam int CELL = 4 * US;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        console_low = 1'b0;
  logic [31:0] buttons = '0;
  logic        line_in;
  logic        line_oe;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;
  logic        rx_error;

  assign line_in = ~(console_low | line_oe);

  n64_controller_responder #(.US_CYCLES(US)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .line_in   (line_in),
    .line_oe   (line_oe),
    .buttons   (buttons),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .busy      (busy),
    .rx_error  (rx_error)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cv_seen  = 0;
  int err_seen = 0;

  // Pulse counters for the error-path checks.
  always @(negedge PCLK) begin
    if (cmd_valid) cv_seen++;
    if (rx_error) err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int lo, input int hi);
    console_low = 1'b1;
    repeat (lo) @(negedge PCLK);
    console_low = 1'b0;
    repeat (hi) @(negedge PCLK);
  endtask

  // Sends the first nb bits of c MSB first; bnd selects the 7/8-cycle boundary widths.
  task automatic send_bits(input logic [7:0] c, input int nb, input bit bnd);
    for (int i = 0; i < nb; i++) begin
      logic b;
      int lo;
      int hi;
      b = c[7-i];
      if (bnd) lo = b ? 2 * US - 1 : 2 * US;
      else     lo = b ? int'($urandom_range(2, 2 * US - 1)) : int'($urandom_range(2 * US, 4 * US - 1));
      hi = bnd ? CELL - lo : int'($urandom_range(3, 12));
      pulse(lo, hi);
    end
  endtask

  // Ends at the negedge where the console releases the stop bit.
  task automatic send_frame(input logic [7:0] c, input bit bnd, input int stop_lo);
    send_bits(c, 8, bnd);
    console_low = 1'b1;
    repeat (stop_lo) @(negedge PCLK);
    console_low = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [31:0] btn, input bit bnd, input bit toggle);
    int n;
    int k;
    int total;
    int mism;
    int last;
    int cellcnt;
    logic [31:0] w;
    logic [31:0] word;
    logic expv;
    buttons = btn;
    n = (c == 8'h00 || c == 8'hff) ? 24 : (c == 8'h01) ? 32 : 0;
    w = (c == 8'h01) ? btn : 32'h0005_0002;
    send_frame(c, bnd, US);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("cv_early", cmd_valid, 1'b0);
    @(negedge PCLK);
    chk("cv_pulse", cmd_valid, 1'b1);
    chk("cmd_byte", cmd_byte, c);
    if (n == 0) begin
      chk("busy_noreply", busy, 1'b0);
      k = 0;
      repeat (40) begin
        @(negedge PCLK);
        if (line_oe) k++;
      end
      chk("noreply_oe", k, 0);
    end else begin
      chk("busy_reply", busy, 1'b1);
      k = 0;
      while (!line_oe && k < 50) begin
        @(negedge PCLK);
        k++;
        if (toggle) buttons = $urandom;
      end
      chk("oe_latency", k, 2 * US);
      total = n * CELL + 2 * US;
      mism = 0;
      last = -1;
      cellcnt = 0;
      word = '0;
      for (int i = 0; i < total + 8; i++) begin
        if (i > 0) begin
          @(negedge PCLK);
          if (toggle) buttons = $urandom;
        end
        if (i < n * CELL) expv = ((i % CELL) < (w[n-1-i/CELL] ? US : 3 * US));
        else              expv = (i < total);
        if (line_oe !== expv) mism++;
        if (line_oe) last = i;
        if (i < n * CELL) begin
          if (i % CELL == 0) cellcnt = 0;
          if (line_oe) cellcnt++;
          if (i % CELL == CELL - 1) word = {word[30:0], (cellcnt < 2 * US)};
        end
      end
      chk("wave", mism, 0);
      chk("reply_word", word, w);
      chk("reply_len", last + 1, total);
      chk("busy_after", busy, 1'b0);
    end
  endtask

  initial begin
    int e0;
    int c0;
    int k;
    logic [7:0] c;
    repeat (3) @(negedge PCLK);
    chk("rst_line_oe", line_oe, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_error", rx_error, 1'b0);
    PRESET = 1'b0;
    repeat (5) @(negedge PCLK);

    run_cmd(8'h01, 32'h8001_00FF, 1'b0, 1'b0);
    run_cmd(8'h00, $urandom, 1'b0, 1'b0);
    run_cmd(8'hff, $urandom, 1'b0, 1'b0);
    run_cmd(8'h02, $urandom, 1'b0, 1'b0);

    // Over-long low mid-byte.
    e0 = err_seen; c0 = cv_seen;
    send_bits(8'hA5, 3, 1'b0);
    pulse(4 * US, 30);
    chk("err_long_low", err_seen - e0, 1);
    chk("cv_long_low", cv_seen - c0, 0);
    chk("busy_long_low", busy, 1'b0);
    run_cmd(8'h01, $urandom, 1'b0, 1'b0);

    // Line left high after a partial byte.
    e0 = err_seen; c0 = cv_seen;
    send_bits(8'h3C, 4, 1'b0);
    repeat (40) @(negedge PCLK);
    chk("err_gap", err_seen - e0, 1);
    chk("cv_gap", cv_seen - c0, 0);
    run_cmd(8'h00, $urandom, 1'b0, 1'b0);

    // Stop bit exactly at the 4 us threshold.
    e0 = err_seen; c0 = cv_seen;
    send_frame(8'h01, 1'b0, 4 * US);
    repeat (30) @(negedge PCLK);
    chk("err_stop", err_seen - e0, 1);
    chk("cv_stop", cv_seen - c0, 0);

    // 7-cycle lows must read as 1, 8-cycle lows as 0.
    run_cmd(8'h01, $urandom, 1'b1, 1'b0);
    run_cmd(8'hff, $urandom, 1'b1, 1'b0);
    run_cmd(8'h00, $urandom, 1'b1, 1'b0);

    // Buttons churn during the reply.
    run_cmd(8'h01, 32'hDEAD_BEEF, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h00;
        1: c = 8'hff;
        2: c = 8'h01;
        default: c = 8'($urandom);
      endcase
      run_cmd(c, $urandom, 1'b0, t[0]);
    end

    // Reset in the middle of reply bit 10.
    buttons = $urandom;
    send_frame(8'h01, 1'b0, US);
    k = 0;
    while (!line_oe && k < 60) begin
      @(negedge PCLK);
      k++;
    end
    chk("rst_oe_started", line_oe, 1'b1);
    repeat (10 * CELL + 2) @(negedge PCLK);
    chk("rst_oe_bit10", line_oe, 1'b1);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_mid_oe", line_oe, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (5) @(negedge PCLK);
    run_cmd(8'h01, $urandom, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
